// File: rtl/decoder_scan.sv
// decoder_scan: SEL_W-to-2**SEL_W one-hot select decoder with registered outputs
// and an auto-scan sequencer for multiplexed digits or row strobes.
//   mode=0 (manual): decodes an index latched by the load strobe.
//   mode=1 (scan)  : steps through every output, holding each for DWELL clocks.
// Optional build macro BLANK_GAP_EN: every index change shows one all-inactive
// clock on out before the new select appears (anti-ghosting).
module decoder_scan #(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  load,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx,
    output logic                  tick
);

    localparam int N_OUT = 2**SEL_W;
    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N_OUT-1:0] OUT_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_MAN,
        ST_SCAN
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [SEL_W-1:0]   idx_nx;
    logic               tick_nx;
    logic [N_OUT-1:0]   out_nx;
    logic [N_OUT-1:0]   onehot;

    // Next state, next index/counter/tick and the registered output image.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        tick_nx  = 1'b0;
        onehot   = '0;
        out_nx   = OUT_IDLE;

        if (!en) begin
            state_nx = ST_OFF;
        end else if (mode) begin
            state_nx = ST_SCAN;
        end else begin
            state_nx = ST_MAN;
        end

        unique case (state_nx)
            ST_OFF: begin
                // Index and dwell count stay frozen so scan can resume in place.
            end
            ST_MAN: begin
                cnt_nx = '0;
                if (load) begin
                    idx_nx = sel_in;
                end
            end
            ST_SCAN: begin
                if (state == ST_SCAN) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx  = '0;
                        idx_nx  = idx + 1'b1;
                        tick_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else if (state == ST_MAN) begin
                    // Entering scan from manual restarts the dwell at the current index.
                    cnt_nx = '0;
                end
                // Entering from OFF keeps the remaining dwell count.
            end
            default: begin
                state_nx = ST_OFF;
            end
        endcase

        if (state_nx != ST_OFF) begin
            onehot[idx_nx] = 1'b1;
            out_nx = (ACTIVE_LOW != 0) ? ~onehot : onehot;
`ifdef BLANK_GAP_EN
            if (idx_nx != idx) begin
                out_nx = OUT_IDLE;
            end
`endif
        end
    end

    // State, index, counter and outputs register together with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update as one edge.
        if (rst) begin
            state <= ST_OFF;
            idx   <= '0;
            cnt   <= '0;
            tick  <= 1'b0;
            out   <= OUT_IDLE;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            tick  <= tick_nx;
            out   <= out_nx;
        end
    end

endmodule
